mux10_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 10:1 bit multiplexer datapath between 10 requesters.
- Produces the registered index select that drives the mux, a one-hot grant back to the requesters, and a valid flag for the downstream consumer.
- Holds a grant until the downstream side signals end of transfer, the owner drops its request, or an optional timeout expires.
- Sits directly in front of the 10-input mux, which stays purely combinational.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/mux10_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux10_rr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the 10-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ    = 10;
  localparam int IDX_W    = 4;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = $clog2(HOLD_MAX);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request bit at or after ptr,
// wrapping from N_REQ-1 back to 0. Purely combinational.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux10_rr_arbiter.sv
// Round-robin arbiter driving the select of a 10:1 bit mux, one idle bubble between grants.
// Optional grant timeout is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux10_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             sel_valid,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             release_grant;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    grant_d       = grant_q;
    release_grant = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        // done or owner withdrawal take precedence, so a coincident limit is not a timeout
        if (done || !req[sel_q]) begin
          release_grant = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          release_grant = 1'b1;
          timeout_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
        if (release_grant) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign sel_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Directed self-checking bench for mux10_rr_arbiter; expected values are hand-computed.
// Timeout scenario runs when MUX_ARB_TIMEOUT_EN is defined, otherwise checks timeout stays low.
module tb_mux10_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [9:0] req;
  logic       done;
  logic [3:0] sel;
  logic [9:0] grant;
  logic       sel_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_mis = 0;

  mux10_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .grant     (grant),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    if (observed != expected) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    check({tag, " sel"}, int'(sel), idx);
    check({tag, " grant"}, int'(grant), 1 << idx);
    check({tag, " valid"}, int'(sel_valid), 1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " grant"}, int'(grant), 0);
    check({tag, " valid"}, int'(sel_valid), 0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    tick();
    check("reset sel", int'(sel), 0);
    expect_idle("reset");
    check("reset timeout", int'(timeout), 0);
    rst = 1'b0;

    // single requester 5, held three cycles then done
    req = 10'b0000100000;
    tick();
    expect_grant("single", 5);
    tick();
    tick();
    expect_grant("single hold", 5);
    done = 1'b1;
    tick();
    expect_idle("single release");
    check("single sel kept", int'(sel), 5);
    done = 1'b0;

    // ptr is 6: with 5 and 7 requesting, 7 wins
    req = 10'b0010100000;
    tick();
    expect_grant("ptr6", 7);
    // owner 7 drops, 5 still requesting
    req = 10'b0000100000;
    tick();
    expect_idle("drop7");
    check("drop7 timeout", int'(timeout), 0);
    tick();
    expect_grant("wrap to 5", 5);
    req = '0;
    tick();
    expect_idle("drop5");

    // ptr is 6: grant 7, then reset mid-grant
    req = 10'b0010000001;
    tick();
    expect_grant("pre-reset", 7);
    rst = 1'b1;
    tick();
    expect_idle("mid-grant reset");
    check("mid-grant reset timeout", int'(timeout), 0);
    check("mid-grant reset sel", int'(sel), 0);
    rst = 1'b0;
    tick();
    expect_grant("after reset ptr0", 0);

    // all requesting from ptr 0: 0..9 then 0, bubble between each
    req  = 10'h3FF;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      expect_grant($sformatf("all k=%0d", k), k % 10);
      done = 1'b1;
      tick();
      check($sformatf("all bubble k=%0d", k), int'(sel_valid), 0);
      done = 1'b0;
    end

    // ptr is 1: grant 8 to move ptr to 9, then wrap-around 9 -> 2
    req = 10'b0100000000;
    tick();
    expect_grant("to ptr9", 8);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 10'b1000000100;
    tick();
    expect_grant("wrap 9", 9);
    done = 1'b1;
    tick();
    expect_idle("wrap 9 release");
    done = 1'b0;
    tick();
    expect_grant("wrap 2", 2);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 10'b0000001110;
    tick();
    expect_grant("ptr3", 3);
    done = 1'b1;
    tick();

    // done in IDLE is ignored
    req = '0;
    tick();
    expect_idle("done in idle");
    done = 1'b0;

    // ptr is 4: owner drop without done
    req = 10'b0000010000;
    tick();
    expect_grant("owner4", 4);
    req = '0;
    tick();
    expect_idle("owner4 drop");
    check("owner4 drop timeout", int'(timeout), 0);
    tick();
    check("owner4 after timeout", int'(timeout), 0);

    // ptr is 5: done and owner drop together advance ptr once
    req = 10'b0000110000;
    tick();
    expect_grant("owner5", 5);
    done = 1'b1;
    req  = '0;
    tick();
    expect_idle("done+drop");
    done = 1'b0;
    req  = 10'b0011000000;
    tick();
    expect_grant("single advance", 6);
    // non-owner request during GRANT does not steal it
    req = 10'b0011000100;
    tick();
    expect_grant("non-owner ignored", 6);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 10'b0001000100;
    tick();
    expect_grant("ptr7 wrap to 2", 2);
    req = '0;
    tick();

`ifdef MUX_ARB_TIMEOUT_EN
    // ptr is 3: 7 held without done releases after 15 GRANT cycles
    req = 10'b0110000000;
    tick();
    expect_grant("to 1", 7);
    for (int n = 2; n <= 15; n++) begin
      tick();
      check($sformatf("hold cycle %0d", n), int'(sel_valid), 1);
      check($sformatf("hold timeout %0d", n), int'(timeout), 0);
    end
    tick();
    expect_idle("timeout release");
    check("timeout pulse", int'(timeout), 1);
    tick();
    expect_grant("after timeout", 8);
    check("timeout pulse ended", int'(timeout), 0);
    req = '0;
    tick();
`else
    // without the timeout feature a held grant persists indefinitely
    req = 10'b0110000000;
    tick();
    expect_grant("long hold", 7);
    for (int n = 2; n <= 20; n++) begin
      tick();
      check($sformatf("long hold %0d", n), int'(sel_valid), 1);
      check($sformatf("long hold timeout %0d", n), int'(timeout), 0);
    end
    req = '0;
    tick();
    expect_idle("long hold drop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
